// File: rtl/adc_spi_multi.sv
// Multi-channel SPI ADC reader: round-robin scan, per-channel result slots, over-setpoint flags with hysteresis.
// Optional build macro ADC_AVG4_EN: report the mean of every four captures per channel instead of each capture.
module adc_spi_multi #(
    parameter int NUM_CH       = 2,
    parameter int CH_W         = 1,
    parameter int DATA_W       = 12,
    parameter int FRAME_BITS   = 16,
    parameter int CLK_DIV_LOG2 = 4,
    parameter int HYST         = 0
) (
    input  logic                 clk48mhz,
    input  logic                 rstn,
    input  logic                 enable,
    output logic                 adc_sclk,
    output logic                 adc_cs_n,
    output logic [CH_W-1:0]      adc_chsel,
    input  logic                 adc_dout,
    output logic [16*NUM_CH-1:0] adc_data,
    output logic                 sample_valid,
    output logic [CH_W-1:0]      sample_ch,
    input  logic [16*NUM_CH-1:0] adc_setpoint,
    output logic [NUM_CH-1:0]    above
);

    localparam int DIV_W  = CLK_DIV_LOG2 + 1;
    localparam int BCNT_W = $clog2(FRAME_BITS + 1);
    localparam int ACC_W  = DATA_W + 2;
    localparam logic [DIV_W-1:0]  SAMPLE_DIV = DIV_W'((1 << CLK_DIV_LOG2) - 1);
    localparam logic [BCNT_W-1:0] LAST_BIT   = BCNT_W'(FRAME_BITS - 1);
    localparam logic [CH_W-1:0]   LAST_CH    = CH_W'(NUM_CH - 1);
    localparam logic [17:0]       HYST_V     = 18'(HYST);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
    logic [DATA_W-1:0]     shift_q, shift_d;
    logic [CH_W-1:0]       ptr_q, ptr_d;
    logic                  sclk_q, sclk_d;
    logic                  cs_n_q, cs_n_d;
    logic [CH_W-1:0]       chsel_q, chsel_d;
    logic [16*NUM_CH-1:0]  data_q, data_d;
    logic                  valid_q, valid_d;
    logic [CH_W-1:0]       sample_ch_q, sample_ch_d;
    logic [NUM_CH-1:0]     above_q, above_d;

    logic                  sample_tick_s;
    logic                  bit_tick_s;
    logic                  report_s;
    logic [DATA_W-1:0]     rep_val_s;

`ifdef ADC_AVG4_EN
    logic [ACC_W-1:0]      acc_q [NUM_CH];
    logic [ACC_W-1:0]      acc_d [NUM_CH];
    logic [1:0]            cnt_q [NUM_CH];
    logic [1:0]            cnt_d [NUM_CH];
    logic [ACC_W-1:0]      sum_s;
`endif

    // Widened to 18 bits so neither sp + HYST nor value + HYST can wrap.
    function automatic logic hyst_next(input logic cur, input logic [17:0] val,
                                       input logic [17:0] sp, input logic [17:0] hy);
        logic res;
        if (val > sp + hy) begin
            res = 1'b1;
        end else if (val + hy < sp) begin
            res = 1'b0;
        end else begin
            res = cur;
        end
        return res;
    endfunction

    assign sample_tick_s = (div_q == SAMPLE_DIV);
    assign bit_tick_s    = &div_q;

    assign adc_sclk     = sclk_q;
    assign adc_cs_n     = cs_n_q;
    assign adc_chsel    = chsel_q;
    assign adc_data     = data_q;
    assign sample_valid = valid_q;
    assign sample_ch    = sample_ch_q;
    assign above        = above_q;

    // Next-state logic for sequencer, deserialiser, result slots and flags.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bcnt_d      = bcnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        cs_n_d      = cs_n_q;
        chsel_d     = chsel_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        sample_ch_d = sample_ch_q;
        above_d     = above_q;
        report_s    = 1'b0;
        rep_val_s   = shift_q;
`ifdef ADC_AVG4_EN
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sum_s       = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                div_d = '0;
                if (enable) begin
                    state_d = ST_FRAME;
                    cs_n_d  = 1'b0;
                    chsel_d = ptr_q;
                    bcnt_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                    cs_n_d  = 1'b1;
                end
            end
            ST_FRAME: begin
                div_d = div_q + DIV_W'(1);
                if (sample_tick_s) begin
                    shift_d = (shift_q << 1) | DATA_W'(adc_dout);
                end else begin
                    shift_d = shift_q;
                end
                if (bit_tick_s && (bcnt_q == LAST_BIT)) begin
                    state_d = ST_GAP;
                    cs_n_d  = 1'b1;
                    bcnt_d  = '0;
                    ptr_d   = (ptr_q == LAST_CH) ? '0 : ptr_q + CH_W'(1);
                    chsel_d = ptr_d;
`ifdef ADC_AVG4_EN
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (ptr_q == CH_W'(i)) begin
                            sum_s = acc_q[i] + ACC_W'(shift_q);
                            if (cnt_q[i] == 2'd3) begin
                                report_s  = 1'b1;
                                rep_val_s = DATA_W'(sum_s >> 2);
                                acc_d[i]  = '0;
                                cnt_d[i]  = 2'd0;
                            end else begin
                                acc_d[i]  = sum_s;
                                cnt_d[i]  = cnt_q[i] + 2'd1;
                            end
                        end else begin
                            acc_d[i] = acc_q[i];
                        end
                    end
`else
                    report_s  = 1'b1;
                    rep_val_s = shift_q;
`endif
                end else if (bit_tick_s) begin
                    bcnt_d = bcnt_q + BCNT_W'(1);
                end else begin
                    bcnt_d = bcnt_q;
                end
            end
            ST_GAP: begin
                div_d = div_q + DIV_W'(1);
                if (bit_tick_s) begin
                    if (enable) begin
                        state_d = ST_FRAME;
                        cs_n_d  = 1'b0;
                        chsel_d = ptr_q;
                        bcnt_d  = '0;
                    end else begin
                        state_d = ST_IDLE;
                        div_d   = '0;
                    end
                end else begin
                    state_d = ST_GAP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                div_d   = '0;
                cs_n_d  = 1'b1;
            end
        endcase

        // The result lands in the first GAP cycle, tagged with the channel just converted.
        if (report_s) begin
            valid_d     = 1'b1;
            sample_ch_d = ptr_q;
            for (int i = 0; i < NUM_CH; i++) begin
                if (ptr_q == CH_W'(i)) begin
                    data_d[16*i +: 16] = 16'(rep_val_s);
                    above_d[i] = hyst_next(above_q[i], 18'(rep_val_s),
                                           18'(adc_setpoint[16*i +: 16]), HYST_V);
                end else begin
                    above_d[i] = above_q[i];
                end
            end
        end else begin
            valid_d = 1'b0;
        end

        sclk_d = (state_d == ST_FRAME) ? ~div_d[DIV_W-1] : 1'b1;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk48mhz) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            bcnt_q      <= '0;
            shift_q     <= '0;
            ptr_q       <= '0;
            sclk_q      <= 1'b1;
            cs_n_q      <= 1'b1;
            chsel_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            sample_ch_q <= '0;
            above_q     <= '0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bcnt_q      <= bcnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            sclk_q      <= sclk_d;
            cs_n_q      <= cs_n_d;
            chsel_q     <= chsel_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            sample_ch_q <= sample_ch_d;
            above_q     <= above_d;
        end
    end

`ifdef ADC_AVG4_EN
    // Per-channel averaging accumulators.
    always_ff @(posedge clk48mhz) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
                cnt_q[i] <= 2'd0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= acc_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_adc_spi_multi.sv
// Directed bench for adc_spi_multi (3 channels, HYST=8): a behavioural ADC serves a per-frame value table.
module tb_adc_spi_multi;

    localparam int NCH = 3;
    localparam int CW  = 2;
    localparam int FRAME_CYC = 544;

    logic              clk48mhz = 1'b0;
    logic              rstn;
    logic              enable;
    logic              adc_sclk;
    logic              adc_cs_n;
    logic [CW-1:0]     adc_chsel;
    logic              adc_dout;
    logic [16*NCH-1:0] adc_data;
    logic              sample_valid;
    logic [CW-1:0]     sample_ch;
    logic [16*NCH-1:0] adc_setpoint;
    logic [NCH-1:0]    above;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    always #5 clk48mhz = ~clk48mhz;

    adc_spi_multi #(
        .NUM_CH(NCH), .CH_W(CW), .DATA_W(12), .FRAME_BITS(16), .CLK_DIV_LOG2(4), .HYST(8)
    ) dut (
        .clk48mhz(clk48mhz), .rstn(rstn), .enable(enable),
        .adc_sclk(adc_sclk), .adc_cs_n(adc_cs_n), .adc_chsel(adc_chsel),
        .adc_dout(adc_dout), .adc_data(adc_data), .sample_valid(sample_valid),
        .sample_ch(sample_ch), .adc_setpoint(adc_setpoint), .above(above)
    );

    always @(posedge clk48mhz) cyc <= cyc + 1;

    // ADC model: MSB out when CS falls, next bit after each SCLK fall.
    logic [15:0]   frame_val [0:31];
    logic [15:0]   sh = 16'h0000;
    logic          cs_prev = 1'b1;
    logic          sclk_prev = 1'b1;
    logic [CW-1:0] fch = '0;
    int            fi = 0;
    int            falls = 0;
    int            chsel_err = 0;

    always @(negedge clk48mhz) begin
        if (cs_prev && !adc_cs_n) begin
            sh = (fi < 32) ? frame_val[fi] : 16'h0000;
            fi = fi + 1;
            falls = 0;
            fch = adc_chsel;
        end else if (!adc_cs_n && sclk_prev && !adc_sclk) begin
            sh = {sh[14:0], 1'b0};
            falls = falls + 1;
        end
        if (!adc_cs_n && (adc_chsel !== fch)) chsel_err = chsel_err + 1;
        adc_dout = sh[15];
        cs_prev = adc_cs_n;
        sclk_prev = adc_sclk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk48mhz);
        #1;
    endtask

    task automatic wait_valid(input int budget, output bit got);
        got = 1'b0;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (sample_valid) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    // Watch for a quiet bus: no pulse, CS and SCLK idle high.
    task automatic idle_watch(input int n, output int bad);
        bad = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (sample_valid !== 1'b0 || adc_cs_n !== 1'b1 || adc_sclk !== 1'b1) bad++;
        end
    endtask

    typedef struct {
        logic [15:0]    val;
        logic [CW-1:0]  ch;
        logic [NCH-1:0] above_exp;
    } vec_t;

    vec_t vec [0:14];

    initial begin
        logic [16*NCH-1:0] exp_data;
        bit got;
        int bad;
        int last_cyc;
        int t0;
        int avg_in [0:3];

        // ch0 sp 0x400, ch1 sp 0x100, ch2 sp 0x400; flags listed as {ch2,ch1,ch0}.
        vec[0]  = '{16'h0ABC, 2'd0, 3'b001};
        vec[1]  = '{16'h0111, 2'd1, 3'b011};
        vec[2]  = '{16'h0333, 2'd2, 3'b011};
        vec[3]  = '{16'h03F7, 2'd0, 3'b010};
        vec[4]  = '{16'h00F7, 2'd1, 3'b000};
        vec[5]  = '{16'h0409, 2'd2, 3'b100};
        vec[6]  = '{16'h0408, 2'd0, 3'b100};
        vec[7]  = '{16'h00FC, 2'd1, 3'b100};
        vec[8]  = '{16'h03F8, 2'd2, 3'b100};
        vec[9]  = '{16'h0409, 2'd0, 3'b101};
        vec[10] = '{16'h0109, 2'd1, 3'b111};
        vec[11] = '{16'h03F7, 2'd2, 3'b011};
        vec[12] = '{16'h0405, 2'd0, 3'b011};
        vec[13] = '{16'h0222, 2'd1, 3'b011};
        vec[14] = '{16'h0111, 2'd2, 3'b011};
        for (int i = 0; i < 32; i++) frame_val[i] = 16'h0000;
`ifndef ADC_AVG4_EN
        for (int i = 0; i < 15; i++) frame_val[i] = vec[i].val;
        frame_val[15] = 16'h05A5;
        frame_val[16] = 16'h0777;
        frame_val[17] = 16'h0123;
`else
        avg_in[0] = 100; avg_in[1] = 101; avg_in[2] = 102; avg_in[3] = 105;
        for (int r = 0; r < 4; r++) begin
            frame_val[3*r]   = 16'(avg_in[r]);
            frame_val[3*r+1] = 16'h0200;
            frame_val[3*r+2] = 16'h0300;
        end
`endif
        adc_setpoint = {16'h0400, 16'h0100, 16'h0400};
        rstn = 1'b0;
        enable = 1'b0;
        repeat (5) tick();
        rstn = 1'b1;

        check("rst_sclk", 64'(adc_sclk), 64'h1);
        check("rst_cs_n", 64'(adc_cs_n), 64'h1);
        check("rst_data", 64'(adc_data), 64'h0);
        check("rst_above", 64'(above), 64'h0);
        check("rst_chsel", 64'(adc_chsel), 64'h0);
        idle_watch(1000, bad);
        check("idle_quiet", 64'(bad), 64'h0);

        enable = 1'b1;
        tick();
        check("start_cs_n", 64'(adc_cs_n), 64'h0);
        check("start_chsel", 64'(adc_chsel), 64'h0);
        exp_data = '0;
        last_cyc = 0;

`ifndef ADC_AVG4_EN
        for (int i = 0; i < 15; i++) begin
            wait_valid(1200, got);
            check($sformatf("v%0d_valid", i), 64'(got), 64'h1);
            exp_data[16*vec[i].ch +: 16] = {4'h0, vec[i].val[11:0]};
            check($sformatf("v%0d_ch", i), 64'(sample_ch), 64'(vec[i].ch));
            check($sformatf("v%0d_data", i), 64'(adc_data), 64'(exp_data));
            check($sformatf("v%0d_above", i), 64'(above), 64'(vec[i].above_exp));
            check($sformatf("v%0d_cs_n", i), 64'(adc_cs_n), 64'h1);
            check($sformatf("v%0d_nextch", i), 64'(adc_chsel),
                  64'((vec[i].ch == 2'd2) ? 2'd0 : vec[i].ch + 2'd1));
            if (i == 0) check("v0_sclk_falls", 64'(falls), 64'd16);
            else check($sformatf("v%0d_spacing", i), 64'(cyc - last_cyc), 64'(FRAME_CYC));
            last_cyc = cyc;
            tick();
            check($sformatf("v%0d_pulse1", i), 64'(sample_valid), 64'h0);
        end

        // enable drops at bit 7: that frame still completes and is stored.
        got = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (fi == 16 && falls >= 7) begin
                got = 1'b1;
                break;
            end
        end
        check("drop_reach_bit7", 64'(got), 64'h1);
        enable = 1'b0;
        wait_valid(1000, got);
        check("drop_valid", 64'(got), 64'h1);
        exp_data[15:0] = 16'h05A5;
        check("drop_ch", 64'(sample_ch), 64'h0);
        check("drop_data", 64'(adc_data), 64'(exp_data));
        check("drop_above", 64'(above), 64'h3);
        repeat (40) tick();
        idle_watch(300, bad);
        check("drop_idle", 64'(bad), 64'h0);

        // rstn pulsed at bit 5 of the ch1 frame.
        enable = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (fi == 17 && falls >= 5) begin
                got = 1'b1;
                break;
            end
        end
        check("abort_reach_bit5", 64'(got), 64'h1);
        rstn = 1'b0;
        enable = 1'b0;
        tick();
        check("abort_sclk", 64'(adc_sclk), 64'h1);
        check("abort_cs_n", 64'(adc_cs_n), 64'h1);
        check("abort_data", 64'(adc_data), 64'h0);
        check("abort_above", 64'(above), 64'h0);
        check("abort_chsel", 64'(adc_chsel), 64'h0);
        check("abort_sample_ch", 64'(sample_ch), 64'h0);
        check("abort_valid", 64'(sample_valid), 64'h0);
        rstn = 1'b1;
        idle_watch(700, bad);
        check("abort_quiet", 64'(bad), 64'h0);

        enable = 1'b1;
        wait_valid(1200, got);
        check("post_valid", 64'(got), 64'h1);
        check("post_ch", 64'(sample_ch), 64'h0);
        check("post_data", 64'(adc_data), 64'h0000_0000_0123);
        check("post_above", 64'(above), 64'h0);
`else
        t0 = cyc;
        wait_valid(8000, got);
        check("avg_valid", 64'(got), 64'h1);
        check("avg_late", 64'((cyc - t0) > 9 * FRAME_CYC), 64'h1);
        check("avg_ch", 64'(sample_ch), 64'h0);
        check("avg_data", 64'(adc_data), 64'h0000_0000_0066);
        check("avg_above", 64'(above), 64'h0);
        last_cyc = cyc;
        wait_valid(1200, got);
        check("avg1_valid", 64'(got), 64'h1);
        check("avg1_ch", 64'(sample_ch), 64'h1);
        check("avg1_data", 64'(adc_data), 64'h0000_0200_0066);
        check("avg1_above", 64'(above), 64'h2);
        check("avg1_spacing", 64'(cyc - last_cyc), 64'(FRAME_CYC));
        enable = 1'b0;
`endif
        check("chsel_stable", 64'(chsel_err), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
